// File: rtl/sub_bytes_pipe.sv
// Pipelined AES SubBytes / InvSubBytes engine: NUM_BYTES lanes per beat, per-beat
// direction tag, per-lane bypass, elastic valid/ready stages with PIPE_STAGES latency.
module sub_bytes_pipe #(
    parameter int unsigned NUM_BYTES   = 16,
    parameter int unsigned PIPE_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_inverse,
    input  logic [NUM_BYTES-1:0]   in_bypass,
    input  logic [8*NUM_BYTES-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_inverse,
    output logic [8*NUM_BYTES-1:0] out_data,
    output logic                   busy
);
    localparam int unsigned W    = 8 * NUM_BYTES;
    localparam int unsigned Last = PIPE_STAGES - 1;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    logic [W-1:0]                   sub_data;
    logic [PIPE_STAGES-1:0]         valid_q, valid_d;
    logic [PIPE_STAGES-1:0]         inv_q, inv_d;
    logic [PIPE_STAGES-1:0]         ready;
    logic [PIPE_STAGES-1:0][W-1:0]  data_q, data_d;

    always_comb begin : lookup
        sub_data = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (in_bypass[i]) begin
                sub_data[8*i +: 8] = in_data[8*i +: 8];
            end else if (in_inverse) begin
                sub_data[8*i +: 8] = INV_SBOX[in_data[8*i +: 8]];
            end else begin
                sub_data[8*i +: 8] = SBOX[in_data[8*i +: 8]];
            end
        end
    end

    // Walk from the output back so each stage sees the ready of the stage after it.
    always_comb begin : ready_chain
        logic acc;
        acc   = out_ready;
        ready = '0;
        for (int k = int'(Last); k >= 0; k--) begin
            acc      = !valid_q[k] || acc;
            ready[k] = acc;
        end
    end

    // Payload only loads with a valid beat, so idle stages keep their contents.
    always_comb begin : next_state
        valid_d = valid_q;
        inv_d   = inv_q;
        data_d  = data_q;
        if (ready[0]) begin
            valid_d[0] = in_valid;
            if (in_valid) begin
                inv_d[0]  = in_inverse;
                data_d[0] = sub_data;
            end
        end
        for (int k = 1; k < PIPE_STAGES; k++) begin
            if (ready[k]) begin
                valid_d[k] = valid_q[k-1];
                if (valid_q[k-1]) begin
                    inv_d[k]  = inv_q[k-1];
                    data_d[k] = data_q[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            inv_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            inv_q   <= inv_d;
            data_q  <= data_d;
        end
    end

    assign in_ready    = ready[0];
    assign out_valid   = valid_q[Last];
    assign out_inverse = inv_q[Last];
    assign out_data    = data_q[Last];
    assign busy        = |valid_q;

endmodule

// File: tb/tb_sub_bytes_pipe.sv
// Directed bench for sub_bytes_pipe: S-box vectors, round trip, bypass, streaming,
// backpressure and mid-flight reset.
module tb_sub_bytes_pipe;
    localparam int NB = 16;
    localparam int PS = 2;
    localparam int W  = 8 * NB;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_inverse;
    logic [NB-1:0] in_bypass;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_inverse;
    logic [W-1:0]  out_data;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    sub_bytes_pipe #(
        .NUM_BYTES  (NB),
        .PIPE_STAGES(PS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inverse (in_inverse),
        .in_bypass  (in_bypass),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inverse(out_inverse),
        .out_data   (out_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (n) step();
    endtask

    // Send one beat into an empty pipe and wait (bounded) for it at the output.
    task automatic run_beat(input logic [W-1:0] d, input logic inv, input logic [NB-1:0] byp,
                            output logic [W-1:0] res, output logic res_inv, output bit got);
        got        = 1'b0;
        res        = '0;
        res_inv    = 1'b0;
        in_valid   = 1'b1;
        in_data    = d;
        in_inverse = inv;
        in_bypass  = byp;
        out_ready  = 1'b1;
        step();
        in_valid   = 1'b0;
        in_inverse = 1'b0;
        in_bypass  = '0;
        in_data    = '0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (out_valid) begin
                res     = out_data;
                res_inv = out_inverse;
                got     = 1'b1;
            end else begin
                step();
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_inverse = 1'b0;
        in_bypass = '0;
        in_data = '0;
        out_ready = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL rst_out_data: got %h want 0", out_data); end
        checks++; if (out_inverse !== 1'b0) begin failures++; $display("FAIL rst_out_inverse: got %b want 0", out_inverse); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_forward();
        logic [W-1:0] r;
        logic         ri;
        bit           got;
        run_beat('0, 1'b0, '0, r, ri, got);
        checks++; if (!got || r !== {NB{8'h63}}) begin failures++; $display("FAIL fwd_zero: got %h want %h", r, {NB{8'h63}}); end
        checks++; if (!got || ri !== 1'b0) begin failures++; $display("FAIL fwd_tag: got %b want 0", ri); end
        run_beat({{(NB-2){8'h00}}, 8'h01, 8'h53}, 1'b0, '0, r, ri, got);
        checks++; if (!got || r !== {{(NB-2){8'h63}}, 8'h7c, 8'hed}) begin
            failures++; $display("FAIL fwd_lanes: got %h want %h", r, {{(NB-2){8'h63}}, 8'h7c, 8'hed});
        end
        idle(3);
    endtask

    task automatic test_inverse();
        logic [W-1:0] r, f, d;
        logic         ri;
        bit           got, got2;
        run_beat({(NB/4){8'h7c, 8'hed, 8'h00, 8'h63}}, 1'b1, '0, r, ri, got);
        checks++; if (!got || r !== {(NB/4){8'h01, 8'h53, 8'h52, 8'h00}}) begin
            failures++; $display("FAIL inv_lanes: got %h want %h", r, {(NB/4){8'h01, 8'h53, 8'h52, 8'h00}});
        end
        checks++; if (!got || ri !== 1'b1) begin failures++; $display("FAIL inv_tag: got %b want 1", ri); end
        for (int b = 0; b < 16; b++) begin
            for (int l = 0; l < NB; l++) d[8*l +: 8] = 8'(b * 16 + l);
            run_beat(d, 1'b0, '0, f, ri, got);
            run_beat(f, 1'b1, '0, r, ri, got2);
            checks++; if (!got || !got2 || r !== d) begin
                failures++; $display("FAIL round_trip_%0d: got %h want %h", b, r, d);
            end
        end
        idle(3);
    endtask

    task automatic test_bypass();
        logic [W-1:0] r, e;
        logic         ri;
        bit           got;
        for (int l = 0; l < NB; l++) e[8*l +: 8] = (l % 2 == 0) ? 8'h63 : 8'h00;
        run_beat('0, 1'b0, 16'hAAAA, r, ri, got);
        checks++; if (!got || r !== e) begin failures++; $display("FAIL bypass_data: got %h want %h", r, e); end
        checks++; if (!got || ri !== 1'b0) begin failures++; $display("FAIL bypass_tag: got %b want 0", ri); end
        idle(3);
    endtask

    // Full bypass keeps payload equal to the input so order is directly visible.
    task automatic test_back_to_back();
        int sent = 0, recv = 0, first_acc = -1, first_out = -1, run = 0, best = 0;
        bit acc;
        out_ready = 1'b1;
        in_bypass = '1;
        for (int c = 0; c < 20; c++) begin
            if (sent < 8) begin
                in_valid   = 1'b1;
                in_data    = {NB{8'(8'h20 + sent)}};
                in_inverse = sent[0];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            acc = in_valid && in_ready;
            step();
            if (acc) begin
                if (first_acc < 0) first_acc = c;
                sent++;
            end
            if (out_valid) begin
                if (first_out < 0) first_out = c + 1;
                run++;
                if (run > best) best = run;
                if (recv < 8) begin
                    checks++; if (out_data !== {NB{8'(8'h20 + recv)}}) begin
                        failures++; $display("FAIL b2b_data_%0d: got %h want %h", recv, out_data, {NB{8'(8'h20 + recv)}});
                    end
                    checks++; if (out_inverse !== recv[0]) begin
                        failures++; $display("FAIL b2b_tag_%0d: got %b want %b", recv, out_inverse, recv[0]);
                    end
                end
                recv++;
            end else begin
                run = 0;
            end
        end
        checks++; if (first_out - first_acc !== PS) begin
            failures++; $display("FAIL b2b_latency: got %0d want %0d", first_out - first_acc, PS);
        end
        checks++; if (recv !== 8) begin failures++; $display("FAIL b2b_count: got %0d want 8", recv); end
        checks++; if (best !== 8) begin failures++; $display("FAIL b2b_consecutive: got %0d want 8", best); end
        in_bypass  = '0;
        in_inverse = 1'b0;
        idle(3);
    endtask

    task automatic test_backpressure();
        int           sent = 0, recv = 0;
        bit           acc, saw_block = 1'b0, stalled_prev = 1'b0;
        logic [W-1:0] held = '0;
        in_bypass = '1;
        in_inverse = 1'b0;
        for (int c = 0; c < 30; c++) begin
            out_ready = !(c >= 3 && c < 8);
            if (sent < 10) begin
                in_valid = 1'b1;
                in_data  = {NB{8'(8'h40 + sent)}};
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stalled_prev) begin
                checks++; if (out_valid !== 1'b1 || out_data !== held) begin
                    failures++; $display("FAIL bp_hold_c%0d: got %b/%h want 1/%h", c, out_valid, out_data, held);
                end
            end
            if (!out_ready && in_valid && !in_ready) saw_block = 1'b1;
            if (out_valid && out_ready) begin
                checks++; if (out_data !== {NB{8'(8'h40 + recv)}}) begin
                    failures++; $display("FAIL bp_data_%0d: got %h want %h", recv, out_data, {NB{8'(8'h40 + recv)}});
                end
                recv++;
            end
            acc          = in_valid && in_ready;
            stalled_prev = out_valid && !out_ready;
            held         = out_data;
            step();
            if (acc) sent++;
        end
        checks++; if (saw_block !== 1'b1) begin failures++; $display("FAIL bp_in_ready_low: got %b want 1", saw_block); end
        checks++; if (recv !== 10) begin failures++; $display("FAIL bp_count: got %0d want 10", recv); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_drained: got busy=%b want 0", busy); end
        in_bypass = '0;
        idle(2);
    endtask

    task automatic test_reset_mid();
        bit stale = 1'b0;
        out_ready = 1'b0;
        in_bypass = '0;
        in_inverse = 1'b0;
        in_valid = 1'b1;
        in_data = {NB{8'h11}};
        step();
        in_data = {NB{8'h22}};
        step();
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1 || out_valid !== 1'b1) begin
            failures++; $display("FAIL mid_loaded: got busy=%b out_valid=%b want 1/1", busy, out_valid);
        end
        rst = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy: got %b want 0", busy); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL mid_out_data: got %h want 0", out_data); end
        rst = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            if (out_valid) stale = 1'b1;
        end
        checks++; if (stale !== 1'b0) begin failures++; $display("FAIL mid_stale: got %b want 0", stale); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_inverse();
        test_bypass();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
